axi_lite_apb_bridge: RTL and testbench
======================================

# axi_lite_apb_bridge

Parametrised AXI4-Lite slave to APB4 master bridge: the next-generation slave endpoint of the AXI-Lite subsystem. It sits behind an AXI-Lite master and converts each read or write into one APB transfer on one of `NUM_SLAVES` peripherals. It adds address decoding, round-robin read/write arbitration, an APB wait-state timeout and error-response mapping.

## Interface
- `ADDR_WIDTH`, 32: AXI and APB address width.
- `DATA_WIDTH`, 32: data width, a multiple of 8. Strobe width is `DATA_WIDTH/8`.
- `NUM_SLAVES`, 4: number of APB peripherals, 1..16.
- `WIN_BITS`, 12: log2 of the byte size of each peripheral window.
- `TIMEOUT`, 16: maximum ACCESS cycles before abort. 0 disables the timeout.

Ports:
- `aclk`  in  1  clock. One clock domain.
- `areset_n`  in  1  asynchronous, active-low reset.
- `s_awvalid`/`s_awready`  in/out  1  write-address handshake.
- `s_awaddr`  in  ADDR_WIDTH  write address.
- `s_wvalid`/`s_wready`  in/out  1  write-data handshake.
- `s_wdata`  in  DATA_WIDTH  write data.
- `s_wstrb`  in  DATA_WIDTH/8  byte strobes.
- `s_bvalid`/`s_bready`  out/in  1  write-response handshake.
- `s_bresp`  out  2  write response.
- `s_arvalid`/`s_arready`  in/out  1  read-address handshake.
- `s_araddr`  in  ADDR_WIDTH  read address.
- `s_rvalid`/`s_rready`  out/in  1  read-data handshake.
- `s_rdata`  out  DATA_WIDTH  read data.
- `s_rresp`  out  2  read response.
- `m_paddr`  out  ADDR_WIDTH  APB address.
- `m_psel`  out  NUM_SLAVES  one-hot peripheral select.
- `m_penable`, `m_pwrite`  out  1  APB enable and direction.
- `m_pwdata`  out  DATA_WIDTH  APB write data.
- `m_pstrb`  out  DATA_WIDTH/8  APB byte strobes.
- `m_prdata`  in  NUM_SLAVES*DATA_WIDTH  read data, concatenated; slave i occupies slice i.
- `m_pready`, `m_pslverr`  in  NUM_SLAVES  per-peripheral ready and error.

## Operation
- **Decode.** Slave index is `addr[WIN_BITS +: clog2(NUM_SLAVES)]`.
  - The address is out of range when any address bit above the index field is nonzero, or the index is `>= NUM_SLAVES`.
  - Out of range: no APB cycle is issued; the response is DECERR (2'b11).
- **FSM states.** IDLE, SETUP, ACCESS, RESP_W, RESP_R.
- **IDLE.**
  - A write is pending when `s_awvalid && s_wvalid`. A read is pending when `s_arvalid`.
  - `s_awready`, `s_wready` and `s_arready` are combinational and high only in IDLE, for the granted request.
  - AW and W are always accepted in the same cycle.
  - When both write and read are pending, grant goes to the type not served last. After reset, write wins.
  - Decoded request → SETUP. Out-of-range request → RESP_W or RESP_R with DECERR.
- **SETUP.** One selected `m_psel` bit high, `m_penable` low; `paddr`, `pwrite`, `pwdata`, `pstrb` are driven. Next state is ACCESS.
- **ACCESS.**
  - `m_penable` high. Hold until the selected `m_pready` is high.
  - On `m_pready`: capture `m_pslverr` (1 → SLVERR 2'b10, else OKAY 2'b00) and, for reads, capture `m_prdata`. Then go to RESP_*, dropping `psel`/`penable`.
  - Timeout: when `TIMEOUT` ACCESS cycles pass without `pready`, abort with SLVERR. Read data in that case is 0.
- **RESP_W / RESP_R.** Hold `s_bvalid`/`s_rvalid` with stable resp/data until the matching ready is high, then return to IDLE. No new request is accepted while a response is outstanding.
- **pwdata / pstrb.** Reads drive `pstrb` as 0; `pwdata` is don't-care.

## Timing
- **Reset values.** All registered outputs are 0. The FSM enters IDLE and the arbiter prefers write.
- **Reset mid-transfer.** Reset drops `psel`/`penable` immediately and discards the pending response.
- **Zero-wait write latency.** Handshake in cycle T; SETUP in T+1; ACCESS in T+2 with `pready`; `s_bvalid` in T+3. Each APB wait state adds 1 cycle.
- **DECERR latency.** Handshake in T; response valid in T+1.
- **Back-to-back throughput.** The earliest next acceptance is the cycle after the response handshake. Minimum 4 cycles per transfer.
- **Timeout counter.** Width `clog2(TIMEOUT+1)`. Cleared on entering ACCESS. Abort fires when count == `TIMEOUT`−1 and `pready` is low.
- **APB stability.** Address and control outputs do not change from SETUP through the end of ACCESS.

## Structure
- Add to `axi_lite_pkg`:
  - `resp_t` enum: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
  - `bridge_state_t` enum for the five FSM states.
- Sub-module `apb_addr_decoder`: combinational, parametrised by ADDR_WIDTH/NUM_SLAVES/WIN_BITS. Outputs are the one-hot select and a `hit` flag.
- The FSM, arbiter, timeout counter and response registers stay in the top module.

## Test plan
All scenarios use defaults.
- Write addr 0x1004, data 0xDEADBEEF, strb 0xF, `pready[1]` tied high → `psel`=4'b0010 in T+1, `penable` in T+2, `s_bvalid` in T+3 with OKAY, `pwdata`=0xDEADBEEF.
- Read 0x2008, `pready[2]` high after 3 wait states, `prdata[2]`=0x12345678 → `s_rvalid` in T+6, rdata 0x12345678, OKAY.
- AW+W and AR asserted together after reset → write serviced first, then read. Repeat → read serviced first.
- Write to 0x8000 → no `psel` ever asserted; DECERR in T+1.
- `pready` stuck low → SLVERR after 16 ACCESS cycles, `psel` dropped. Separately, `pslverr` high with `pready` → SLVERR.
- `s_bready` low for 5 cycles with a new AR pending → `s_bvalid`/`s_bresp` stable and `s_arready` low until `s_bready`.
- `areset_n` low during ACCESS → `psel`/`penable` 0 in the same cycle, no response issued, IDLE after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite subsystem: response codes, bridge FSM states
// and a small helper for index-field widths.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESP_W = 3'd3,
    RESP_R = 3'd4
  } bridge_state_t;

  // Width of a field that indexes n items; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational APB address decoder: maps an address onto a one-hot
// peripheral select and flags addresses that fall outside every window.
module apb_addr_decoder
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int WIN_BITS   = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  hit_o
);

  localparam int IDX_W  = idx_width(NUM_SLAVES);
  localparam int HI_LSB = WIN_BITS + IDX_W;

  logic [IDX_W-1:0] idx;
  logic             upper_zero;

  assign idx = addr_i[WIN_BITS +: IDX_W];

  // Any set bit above the index field, or an index past the last slave, misses.
  always_comb begin
    upper_zero = 1'b1;
    for (int b = HI_LSB; b < ADDR_WIDTH; b++) begin
      if (addr_i[b]) upper_zero = 1'b0;
    end
    hit_o = upper_zero && (32'(idx) < 32'(NUM_SLAVES));
    sel_o = '0;
    if (hit_o) sel_o[idx] = 1'b1;
  end

endmodule

// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge. Each accepted AXI read or write
// becomes exactly one APB transfer (or an immediate DECERR when the address
// misses every peripheral window). Reads and writes share one FSM; a
// round-robin arbiter picks between them when both are pending.
module axi_lite_apb_bridge
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int WIN_BITS   = 12,
  parameter int TIMEOUT    = 16
) (
  input  logic                             aclk,
  input  logic                             areset_n,
  // AXI4-Lite write address / data / response
  input  logic                             s_awvalid,
  output logic                             s_awready,
  input  logic [ADDR_WIDTH-1:0]            s_awaddr,
  input  logic                             s_wvalid,
  output logic                             s_wready,
  input  logic [DATA_WIDTH-1:0]            s_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s_wstrb,
  output logic                             s_bvalid,
  input  logic                             s_bready,
  output logic [1:0]                       s_bresp,
  // AXI4-Lite read address / data
  input  logic                             s_arvalid,
  output logic                             s_arready,
  input  logic [ADDR_WIDTH-1:0]            s_araddr,
  output logic                             s_rvalid,
  input  logic                             s_rready,
  output logic [DATA_WIDTH-1:0]            s_rdata,
  output logic [1:0]                       s_rresp,
  // APB4 master
  output logic [ADDR_WIDTH-1:0]            m_paddr,
  output logic [NUM_SLAVES-1:0]            m_psel,
  output logic                             m_penable,
  output logic                             m_pwrite,
  output logic [DATA_WIDTH-1:0]            m_pwdata,
  output logic [DATA_WIDTH/8-1:0]          m_pstrb,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata,
  input  logic [NUM_SLAVES-1:0]            m_pready,
  input  logic [NUM_SLAVES-1:0]            m_pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  bridge_state_t           state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,   paddr_d;
  logic                    pwrite_q,  pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,  pwdata_d;
  logic [STRB_W-1:0]       pstrb_q,   pstrb_d;
  logic [NUM_SLAVES-1:0]   sel_q,     sel_d;
  resp_t                   resp_q,    resp_d;
  logic [DATA_WIDTH-1:0]   rdata_q,   rdata_d;
  logic                    last_wr_q, last_wr_d;
  logic [CNT_W-1:0]        tcnt_q,    tcnt_d;

  logic                    wr_pend;
  logic                    rd_pend;
  logic                    grant_wr;
  logic                    grant_rd;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_hit;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    timeout_hit;

  // Round-robin arbiter: on contention the type not served last wins;
  // last_wr_q resets low so a write wins the first contention.
  always_comb begin
    wr_pend  = s_awvalid && s_wvalid;
    rd_pend  = s_arvalid;
    grant_wr = (state_q == IDLE) && wr_pend && (!rd_pend || !last_wr_q);
    grant_rd = (state_q == IDLE) && rd_pend && !grant_wr;
    req_addr = grant_wr ? s_awaddr : s_araddr;
  end

  assign s_awready = grant_wr;
  assign s_wready  = grant_wr;
  assign s_arready = grant_rd;

  apb_addr_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .WIN_BITS   (WIN_BITS)
  ) u_dec (
    .addr_i (req_addr),
    .sel_o  (dec_sel),
    .hit_o  (dec_hit)
  );

  // Pick ready, error and read data of the peripheral currently addressed.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_ready = sel_ready | m_pready[i];
        sel_err   = sel_err   | m_pslverr[i];
        sel_rdata = sel_rdata | m_prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The abort fires on the TIMEOUT-th ACCESS cycle; TIMEOUT of 0 never aborts.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state logic: request capture, APB sequencing and response latching.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    sel_d     = sel_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    last_wr_d = last_wr_q;
    tcnt_d    = tcnt_q;
    case (state_q)
      IDLE: begin
        if (grant_wr || grant_rd) begin
          last_wr_d = grant_wr;
          if (dec_hit) begin
            state_d  = SETUP;
            paddr_d  = req_addr;
            pwrite_d = grant_wr;
            pwdata_d = s_wdata;
            pstrb_d  = grant_wr ? s_wstrb : '0;
            sel_d    = dec_sel;
          end else begin
            state_d = grant_wr ? RESP_W : RESP_R;
            resp_d  = DECERR;
            rdata_d = '0;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        tcnt_d  = '0;
      end
      ACCESS: begin
        if (sel_ready) begin
          resp_d  = sel_err ? SLVERR : OKAY;
          if (!pwrite_q) rdata_d = sel_rdata;
          state_d = pwrite_q ? RESP_W : RESP_R;
        end else if (timeout_hit) begin
          resp_d  = SLVERR;
          rdata_d = '0;
          state_d = pwrite_q ? RESP_W : RESP_R;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end
      RESP_W: begin
        if (s_bready) state_d = IDLE;
      end
      RESP_R: begin
        if (s_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any transfer.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      sel_q     <= '0;
      resp_q    <= OKAY;
      rdata_q   <= '0;
      last_wr_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      sel_q     <= sel_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      last_wr_q <= last_wr_d;
      tcnt_q    <= tcnt_d;
    end
  end

  // APB and AXI response outputs decode directly from the state register so
  // an asynchronous reset removes psel/penable and any pending response at once.
  always_comb begin
    m_psel    = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
    m_penable = (state_q == ACCESS);
    m_paddr   = paddr_q;
    m_pwrite  = pwrite_q;
    m_pwdata  = pwdata_q;
    m_pstrb   = pstrb_q;
    s_bvalid  = (state_q == RESP_W);
    s_rvalid  = (state_q == RESP_R);
    s_bresp   = resp_q;
    s_rresp   = resp_q;
    s_rdata   = rdata_q;
  end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Testbench for axi_lite_apb_bridge: a table of single transactions against a
// behavioural APB slave, plus hand-written arbitration, backpressure and
// reset-during-ACCESS sequences.
module tb_axi_lite_apb_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int SW = DW / 8;

  logic           aclk = 1'b0;
  logic           areset_n;
  logic           s_awvalid, s_awready, s_wvalid, s_wready;
  logic [AW-1:0]  s_awaddr;
  logic [DW-1:0]  s_wdata;
  logic [SW-1:0]  s_wstrb;
  logic           s_bvalid, s_bready;
  logic [1:0]     s_bresp;
  logic           s_arvalid, s_arready;
  logic [AW-1:0]  s_araddr;
  logic           s_rvalid, s_rready;
  logic [DW-1:0]  s_rdata;
  logic [1:0]     s_rresp;
  logic [AW-1:0]  m_paddr;
  logic [NS-1:0]  m_psel;
  logic           m_penable, m_pwrite;
  logic [DW-1:0]  m_pwdata;
  logic [SW-1:0]  m_pstrb;
  logic [NS*DW-1:0] m_prdata;
  logic [NS-1:0]  m_pready, m_pslverr;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axi_lite_apb_bridge #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .NUM_SLAVES (NS), .WIN_BITS (12), .TIMEOUT (16)
  ) dut (
    .aclk (aclk), .areset_n (areset_n),
    .s_awvalid (s_awvalid), .s_awready (s_awready), .s_awaddr (s_awaddr),
    .s_wvalid (s_wvalid), .s_wready (s_wready), .s_wdata (s_wdata), .s_wstrb (s_wstrb),
    .s_bvalid (s_bvalid), .s_bready (s_bready), .s_bresp (s_bresp),
    .s_arvalid (s_arvalid), .s_arready (s_arready), .s_araddr (s_araddr),
    .s_rvalid (s_rvalid), .s_rready (s_rready), .s_rdata (s_rdata), .s_rresp (s_rresp),
    .m_paddr (m_paddr), .m_psel (m_psel), .m_penable (m_penable), .m_pwrite (m_pwrite),
    .m_pwdata (m_pwdata), .m_pstrb (m_pstrb), .m_prdata (m_prdata),
    .m_pready (m_pready), .m_pslverr (m_pslverr)
  );

  // Behavioural APB slave: ready after wait_cfg ACCESS cycles unless stuck.
  int            acc_cnt;
  int            wait_cfg = 0;
  bit            stuck = 1'b0;
  bit            err_cfg = 1'b0;
  logic [DW-1:0] slave_data [NS];
  logic          pr_now;

  always @(posedge aclk or negedge areset_n) begin
    if (!areset_n)      acc_cnt <= 0;
    else if (!m_penable) acc_cnt <= 0;
    else                acc_cnt <= acc_cnt + 1;
  end

  assign pr_now    = m_penable && !stuck && (acc_cnt >= wait_cfg);
  assign m_pready  = pr_now ? m_psel : '0;
  assign m_pslverr = err_cfg ? m_psel : '0;

  always_comb begin
    m_prdata = '0;
    for (int i = 0; i < NS; i++) m_prdata[i*DW +: DW] = slave_data[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input bit wr, input string name);
    int n = 0;
    while (!(wr ? s_bvalid : s_rvalid) && n < 40) begin
      @(posedge aclk); #1;
      n++;
    end
    chk({name, ".valid"}, wr ? s_bvalid : s_rvalid, 1'b1);
  endtask

  task automatic resp_handshake(input bit wr);
    if (wr) s_bready = 1'b1; else s_rready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0;
    s_rready = 1'b0;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset_n = 1'b1;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          stuck;
    bit          err;
    logic [3:0]  exp_sel;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v, input string tag);
    logic [3:0]  sel1, sel_resp;
    logic [31:0] paddr1, pwdata1;
    logic [3:0]  pstrb1;
    logic        pen1, pen2, pwr1, any_sel, got;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    wait_cfg = v.waits; stuck = v.stuck; err_cfg = v.err;
    sel1 = '0; sel_resp = '0; paddr1 = '0; pwdata1 = '0; pstrb1 = '0;
    pen1 = 1'b0; pen2 = 1'b0; pwr1 = 1'b0; any_sel = 1'b0; got = 1'b0;
    resp = '0; rdata = '0; lat = 0;
    @(posedge aclk); #1;
    if (v.wr) begin
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_awaddr = v.addr; s_wdata = v.wdata; s_wstrb = v.strb;
    end else begin
      s_arvalid = 1'b1; s_araddr = v.addr;
    end
    #1;
    chk({tag, ".ready"}, v.wr ? s_awready & s_wready : s_arready, 1'b1);
    @(posedge aclk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (k > 1) begin @(posedge aclk); #1; end
      if (m_psel != '0) any_sel = 1'b1;
      if (k == 1) begin
        sel1 = m_psel; pen1 = m_penable; paddr1 = m_paddr; pwr1 = m_pwrite;
        pwdata1 = m_pwdata; pstrb1 = m_pstrb;
      end
      if (k == 2) pen2 = m_penable;
      if (v.wr ? s_bvalid : s_rvalid) begin
        got = 1'b1; lat = k; sel_resp = m_psel;
        resp = v.wr ? s_bresp : s_rresp; rdata = s_rdata;
      end
    end
    chk({tag, ".latency"}, lat, v.exp_lat);
    chk({tag, ".resp"}, resp, v.exp_resp);
    chk({tag, ".psel_at_resp"}, sel_resp, 4'b0000);
    if (v.exp_resp == 2'b11) begin
      chk({tag, ".no_psel"}, any_sel, 1'b0);
    end else begin
      chk({tag, ".psel_setup"}, sel1, v.exp_sel);
      chk({tag, ".penable_setup"}, pen1, 1'b0);
      chk({tag, ".penable_access"}, pen2, 1'b1);
      chk({tag, ".paddr"}, paddr1, v.addr);
      chk({tag, ".pwrite"}, pwr1, v.wr);
      chk({tag, ".pstrb"}, pstrb1, v.wr ? v.strb : 4'h0);
      if (v.wr) chk({tag, ".pwdata"}, pwdata1, v.wdata);
      else      chk({tag, ".rdata"}, rdata, v.exp_rdata);
    end
    if (got) begin
      resp_handshake(v.wr);
      chk({tag, ".valid_drop"}, v.wr ? s_bvalid : s_rvalid, 1'b0);
    end
    stuck = 1'b0; err_cfg = 1'b0; wait_cfg = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] bresp0;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 0; s_rready = 0;
    s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
    slave_data[0] = 32'h0BAD_0000;
    slave_data[1] = 32'h1111_1111;
    slave_data[2] = 32'h1234_5678;
    slave_data[3] = 32'hCAFE_F00D;

    //          wr  addr          wdata         strb waits stk err sel      resp   rdata         lat
    vecs[0] = '{1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 4'b0010, 2'b00, 32'h0,        3};
    vecs[1] = '{0, 32'h0000_2008, 32'h0,         4'h0, 3, 0, 0, 4'b0100, 2'b00, 32'h1234_5678, 6};
    vecs[2] = '{1, 32'h0000_8000, 32'h0102_0304, 4'hF, 0, 0, 0, 4'b0000, 2'b11, 32'h0,        1};
    vecs[3] = '{0, 32'h0000_3FFC, 32'h0,         4'h0, 1, 0, 1, 4'b1000, 2'b10, 32'hCAFE_F00D, 4};
    vecs[4] = '{1, 32'h0000_0000, 32'h0000_A5A5, 4'h3, 0, 0, 1, 4'b0001, 2'b10, 32'h0,        3};
    vecs[5] = '{0, 32'h0000_0010, 32'h0,         4'h0, 0, 1, 0, 4'b0001, 2'b10, 32'h0,        18};
    vecs[6] = '{0, 32'h0001_0000, 32'h0,         4'h0, 0, 0, 0, 4'b0000, 2'b11, 32'h0,        1};
    vecs[7] = '{1, 32'h0000_2FFF, 32'h7654_3210, 4'h9, 2, 0, 0, 4'b0100, 2'b00, 32'h0,        5};

    // Reset values
    areset_n = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst.psel", m_psel, 4'b0000);
    chk("rst.penable", m_penable, 1'b0);
    chk("rst.bvalid", s_bvalid, 1'b0);
    chk("rst.rvalid", s_rvalid, 1'b0);
    chk("rst.paddr", m_paddr, 32'h0);
    chk("rst.rdata", s_rdata, 32'h0);
    #1 areset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Arbitration: write wins first after reset, then the waiting read,
    // then the re-presented write.
    do_reset();
    @(posedge aclk); #1;
    s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h1000; s_wdata = 32'hA5A5_0001; s_wstrb = 4'hF;
    s_arvalid = 1; s_araddr = 32'h2000;
    #1;
    chk("arb1.awready", s_awready, 1'b1);
    chk("arb1.arready", s_arready, 1'b0);
    @(posedge aclk); #1;
    s_awvalid = 0; s_wvalid = 0;
    chk("arb1.pwrite", m_pwrite, 1'b1);
    chk("arb1.psel", m_psel, 4'b0010);
    wait_valid(1, "arb1");
    resp_handshake(1);
    s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h3000; s_wdata = 32'h0000_0077;
    #1;
    chk("arb2.arready", s_arready, 1'b1);
    chk("arb2.awready", s_awready, 1'b0);
    @(posedge aclk); #1;
    s_arvalid = 0;
    chk("arb2.pwrite", m_pwrite, 1'b0);
    chk("arb2.psel", m_psel, 4'b0100);
    wait_valid(0, "arb2");
    chk("arb2.rdata", s_rdata, 32'h1234_5678);
    resp_handshake(0);
    #1;
    chk("arb3.awready", s_awready, 1'b1);
    @(posedge aclk); #1;
    s_awvalid = 0; s_wvalid = 0;
    chk("arb3.psel", m_psel, 4'b1000);
    chk("arb3.pwdata", m_pwdata, 32'h0000_0077);
    wait_valid(1, "arb3");
    resp_handshake(1);

    // Backpressure on B with a read waiting: response held, no new accept.
    err_cfg = 1'b1;
    @(posedge aclk); #1;
    s_awvalid = 1; s_wvalid = 1; s_awaddr = 32'h1008; s_wdata = 32'h55; s_wstrb = 4'hF;
    @(posedge aclk); #1;
    s_awvalid = 0; s_wvalid = 0;
    wait_valid(1, "bp");
    err_cfg = 1'b0;
    bresp0 = s_bresp;
    chk("bp.bresp", bresp0, 2'b10);
    s_arvalid = 1; s_araddr = 32'h0004;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp.bvalid%0d", c), s_bvalid, 1'b1);
      chk($sformatf("bp.bresp%0d", c), s_bresp, bresp0);
      chk($sformatf("bp.arready%0d", c), s_arready, 1'b0);
      @(posedge aclk); #1;
    end
    s_bready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0;
    #1;
    chk("bp.arready_after", s_arready, 1'b1);
    @(posedge aclk); #1;
    s_arvalid = 0;
    wait_valid(0, "bp.read");
    chk("bp.rdata", s_rdata, 32'h0BAD_0000);
    resp_handshake(0);

    // Reset asserted during ACCESS.
    stuck = 1'b1;
    @(posedge aclk); #1;
    s_arvalid = 1; s_araddr = 32'h1000;
    @(posedge aclk); #1;
    s_arvalid = 0;
    @(posedge aclk); #1;
    chk("rstmid.penable_before", m_penable, 1'b1);
    #2 areset_n = 1'b0;
    #1;
    chk("rstmid.psel", m_psel, 4'b0000);
    chk("rstmid.penable", m_penable, 1'b0);
    @(posedge aclk); #1;
    areset_n = 1'b1;
    stuck = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge aclk); #1;
      chk($sformatf("rstmid.rvalid%0d", c), s_rvalid, 1'b0);
      chk($sformatf("rstmid.psel%0d", c), m_psel, 4'b0000);
    end
    s_arvalid = 1; s_araddr = 32'h2000;
    #1;
    chk("rstmid.idle_arready", s_arready, 1'b1);
    @(posedge aclk); #1;
    s_arvalid = 0;
    wait_valid(0, "rstmid.read");
    chk("rstmid.rresp", s_rresp, 2'b00);
    resp_handshake(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
